// File: rtl/counter_access_port_if.sv
// counter_access_port_if
//   CPU-side bus of one 8254 counter channel: write/read strobes, write data,
//   and registered read data.
//   Modports:
//     master - CPU side: drives cw_wr, data_wr, data_rd, din; reads dout
//     slave  - channel side: reads the strobes and din; drives dout
interface counter_access_port_if;
    logic       cw_wr;    // din is a control word for this channel
    logic       data_wr;  // din is a count byte
    logic       data_rd;  // read one count byte
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output cw_wr, data_wr, data_rd, din, input dout);
    modport slave  (input cw_wr, data_wr, data_rd, din, output dout);
endinterface

// File: rtl/counter_access_port.sv
// counter_access_port
//   Bus-side access logic for one 8254 counter channel. Decodes control
//   words (RW field and latch command), assembles count-byte writes into a
//   16-bit count with a one-cycle load pulse, and returns live or latched
//   count bytes according to the programmed RW mode.
//
//   Ports:
//     clk, rst       clock; synchronous active-low reset
//     bus            counter_access_port_if.slave (strobes, din, dout)
//     current_count  live count from the counter core
//     load           one-cycle pulse to the core
//     new_count      assembled count, held after the load pulse
//     rw_mode        current RW access mode
//     count_hold     (only with COUNT_WRITE_HOLD_EN) freezes the core
//                    between the two bytes of a mode-11 write
//
//   Optional feature macro: COUNT_WRITE_HOLD_EN
module counter_access_port #(
    parameter logic [1:0] RESET_RW = 2'b11
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_access_port_if.slave   bus,
    input  logic [15:0]            current_count,
    output logic                   load,
    output logic [15:0]            new_count,
    output logic [1:0]             rw_mode
`ifdef COUNT_WRITE_HOLD_EN
    ,
    output logic                   count_hold
`endif
);

    localparam logic [1:0] RW_LSB  = 2'b01;
    localparam logic [1:0] RW_MSB  = 2'b10;
    localparam logic [1:0] RW_BOTH = 2'b11;

    logic        wr_ptr;     // 0: next byte is LSB, 1: next byte is MSB
    logic        rd_ptr;
    logic [7:0]  lsb_hold;
    logic        latched;
    logic [15:0] latch_reg;

    logic [1:0]  rw_field;
    logic [15:0] rd_src;
    logic        rd_hi;
    logic        rd_last;
    logic        latched_after_rd;

    always_comb begin
        rw_field = bus.din[5:4];
        rd_src   = latched ? latch_reg : current_count;
        rd_hi    = (rw_mode == RW_MSB) || ((rw_mode == RW_BOTH) && rd_ptr);
        // The read that returns the final byte of the mode consumes the latch.
        rd_last  = (rw_mode != RW_BOTH) || rd_ptr;
        // A simultaneous latch command sees the flag as left by the read.
        latched_after_rd = latched && !(bus.data_rd && rd_last);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rw_mode   <= RESET_RW;
            bus.dout  <= 8'h00;
            load      <= 1'b0;
            new_count <= 16'h0000;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            lsb_hold  <= 8'h00;
            latched   <= 1'b0;
            latch_reg <= 16'h0000;
        end else begin
            load <= 1'b0;

            // Read path runs on pre-command state; a control word in the
            // same cycle overrides the pointer/flag updates below.
            if (bus.data_rd) begin
                bus.dout <= rd_hi ? rd_src[15:8] : rd_src[7:0];
                if (rw_mode == RW_BOTH)
                    rd_ptr <= ~rd_ptr;
            end
            latched <= latched_after_rd;

            if (bus.cw_wr) begin
                if (rw_field != 2'b00) begin
                    rw_mode <= rw_field;
                    wr_ptr  <= 1'b0;  // discards a half-written count
                    rd_ptr  <= 1'b0;
                    latched <= 1'b0;
                end else if (!latched_after_rd) begin
                    latch_reg <= current_count;
                    latched   <= 1'b1;
                end
            end else if (bus.data_wr) begin
                case (rw_mode)
                    RW_LSB: begin
                        new_count <= {8'h00, bus.din};
                        load      <= 1'b1;
                    end
                    RW_MSB: begin
                        new_count <= {bus.din, 8'h00};
                        load      <= 1'b1;
                    end
                    default: begin
                        if (!wr_ptr) begin
                            lsb_hold <= bus.din;
                            wr_ptr   <= 1'b1;
                        end else begin
                            new_count <= {bus.din, lsb_hold};
                            wr_ptr    <= 1'b0;
                            load      <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef COUNT_WRITE_HOLD_EN
    // wr_ptr is high exactly from the cycle after a mode-11 LSB write until
    // the MSB write edge (the load cycle), and is cleared by a mode-setting
    // control word or reset, which is the required hold window.
    assign count_hold = wr_ptr;
`endif

endmodule

// File: tb/tb_counter_access_port.sv
module tb_counter_access_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] current_count = 16'h0000;
    logic        load;
    logic [15:0] new_count;
    logic [1:0]  rw_mode;
`ifdef COUNT_WRITE_HOLD_EN
    logic        count_hold;
`endif

    int checks   = 0;
    int failures = 0;
    int load_pulses = 0;

    counter_access_port_if bus();

    counter_access_port #(.RESET_RW(2'b11)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .current_count (current_count),
        .load          (load),
        .new_count     (new_count),
        .rw_mode       (rw_mode)
`ifdef COUNT_WRITE_HOLD_EN
        ,
        .count_hold    (count_hold)
`endif
    );

    always #5 clk = ~clk;

    // Counts load pulses; samples the pre-edge value of load.
    always @(posedge clk) if (load === 1'b1) load_pulses <= load_pulses + 1;

    // Stimulus helpers: called at a negedge, return at the next negedge.
    task automatic cw(input logic [7:0] b);
        bus.din = b; bus.cw_wr = 1'b1;
        @(negedge clk);
        bus.cw_wr = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        bus.din = b; bus.data_wr = 1'b1;
        @(negedge clk);
        bus.data_wr = 1'b0;
    endtask

    task automatic rd();
        bus.data_rd = 1'b1;
        @(negedge clk);
        bus.data_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.cw_wr = 0; bus.data_wr = 0; bus.data_rd = 0; bus.din = 8'h00;
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        checks++; if (bus.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", load); end
        checks++; if (new_count !== 16'h0000) begin failures++; $display("FAIL reset_new_count got=%h exp=0000", new_count); end
        checks++; if (rw_mode !== 2'b11) begin failures++; $display("FAIL reset_rw_mode got=%b exp=11", rw_mode); end
`ifdef COUNT_WRITE_HOLD_EN
        checks++; if (count_hold !== 1'b0) begin failures++; $display("FAIL reset_count_hold got=%b exp=0", count_hold); end
`endif
    endtask

    task automatic test_mode11_write();
        cw(8'h30);
        load_pulses = 0;
        wr(8'h34);
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL m11_no_load_lsb got=%b exp=0", load); end
        wr(8'h12);
        checks++; if (load !== 1'b1) begin failures++; $display("FAIL m11_load got=%b exp=1", load); end
        checks++; if (new_count !== 16'h1234) begin failures++; $display("FAIL m11_new_count got=%h exp=1234", new_count); end
        idle(1);
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL m11_load_one_cycle got=%b exp=0", load); end
        checks++; if (load_pulses !== 1) begin failures++; $display("FAIL m11_pulse_count got=%0d exp=1", load_pulses); end
    endtask

    task automatic test_mode01_10();
        cw(8'h10);
        checks++; if (rw_mode !== 2'b01) begin failures++; $display("FAIL m01_rw_mode got=%b exp=01", rw_mode); end
        wr(8'hA5);
        checks++; if (load !== 1'b1 || new_count !== 16'h00A5) begin failures++; $display("FAIL m01_write got=%b/%h exp=1/00a5", load, new_count); end
        cw(8'h20);
        wr(8'h5A);
        checks++; if (load !== 1'b1 || new_count !== 16'h5A00) begin failures++; $display("FAIL m10_write got=%b/%h exp=1/5a00", load, new_count); end
    endtask

    task automatic test_back_to_back();
        cw(8'h10);
        wr(8'h01);
        checks++; if (load !== 1'b1 || new_count !== 16'h0001) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/0001", load, new_count); end
        wr(8'h00);
        checks++; if (load !== 1'b1 || new_count !== 16'h0000) begin failures++; $display("FAIL b2b_zero got=%b/%h exp=1/0000", load, new_count); end
    endtask

    task automatic test_latch();
        cw(8'h30);
        current_count = 16'hBEEF;
        cw(8'h00);
        current_count = 16'h0001;
        rd();
        checks++; if (bus.dout !== 8'hEF) begin failures++; $display("FAIL latch_lo got=%h exp=ef", bus.dout); end
        rd();
        checks++; if (bus.dout !== 8'hBE) begin failures++; $display("FAIL latch_hi got=%h exp=be", bus.dout); end
        rd();
        checks++; if (bus.dout !== 8'h01) begin failures++; $display("FAIL latch_live got=%h exp=01", bus.dout); end
        checks++; if (rw_mode !== 2'b11) begin failures++; $display("FAIL latch_rw_kept got=%b exp=11", rw_mode); end
    endtask

    task automatic test_repeat_latch();
        cw(8'h30);
        current_count = 16'h1111;
        cw(8'h00);
        current_count = 16'h2222;
        cw(8'h00);
        rd();
        checks++; if (bus.dout !== 8'h11) begin failures++; $display("FAIL relatch_lo got=%h exp=11", bus.dout); end
        rd();
        checks++; if (bus.dout !== 8'h11) begin failures++; $display("FAIL relatch_hi got=%h exp=11", bus.dout); end
        rd();
        checks++; if (bus.dout !== 8'h22) begin failures++; $display("FAIL relatch_live got=%h exp=22", bus.dout); end
    endtask

    task automatic test_abort();
        cw(8'h30);
        load_pulses = 0;
        wr(8'h34);
        cw(8'h30);
        wr(8'h78);
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL abort_no_load got=%b exp=0", load); end
        wr(8'h56);
        checks++; if (load !== 1'b1 || new_count !== 16'h5678) begin failures++; $display("FAIL abort_load got=%b/%h exp=1/5678", load, new_count); end
        idle(1);
        checks++; if (load_pulses !== 1) begin failures++; $display("FAIL abort_pulse_count got=%0d exp=1", load_pulses); end
    endtask

    task automatic test_reset_mid();
        current_count = 16'h9876;
        cw(8'h10);
        rd();               // leaves dout nonzero before the reset
        cw(8'h30);
        wr(8'h34);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        checks++; if (bus.dout !== 8'h00 || load !== 1'b0 || new_count !== 16'h0000 || rw_mode !== 2'b11) begin
            failures++; $display("FAIL rstmid_outputs got=%h/%b/%h/%b exp=00/0/0000/11", bus.dout, load, new_count, rw_mode); end
        wr(8'h12);          // pointer back at LSB: no load
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL rstmid_ptr_cleared got=%b exp=0", load); end
        // Completing write coincides with reset: the load must be cancelled.
        bus.din = 8'hBB; bus.data_wr = 1'b1; rst = 1'b0;
        @(negedge clk);
        bus.data_wr = 1'b0; rst = 1'b1;
        checks++; if (load !== 1'b0 || new_count !== 16'h0000) begin failures++; $display("FAIL rstmid_cancel got=%b/%h exp=0/0000", load, new_count); end
    endtask

    task automatic test_simultaneous();
        // cw with data_wr: control word wins, byte dropped.
        cw(8'h30);
        load_pulses = 0;
        bus.din = 8'h20; bus.cw_wr = 1'b1; bus.data_wr = 1'b1;
        @(negedge clk);
        bus.cw_wr = 1'b0; bus.data_wr = 1'b0;
        checks++; if (load !== 1'b0 || rw_mode !== 2'b10) begin failures++; $display("FAIL sim_cw_wr got=%b/%b exp=0/10", load, rw_mode); end
        // cw with data_rd: read served in old mode 11 (low byte).
        cw(8'h30);
        current_count = 16'hABCD;
        bus.din = 8'h10; bus.cw_wr = 1'b1; bus.data_rd = 1'b1;
        @(negedge clk);
        bus.cw_wr = 1'b0; bus.data_rd = 1'b0;
        checks++; if (bus.dout !== 8'hCD || rw_mode !== 2'b01) begin failures++; $display("FAIL sim_cw_rd got=%h/%b exp=cd/01", bus.dout, rw_mode); end
        // data_wr with data_rd: independent pointers.
        cw(8'h30);
        current_count = 16'h4321;
        bus.din = 8'h99; bus.data_wr = 1'b1; bus.data_rd = 1'b1;
        @(negedge clk);
        checks++; if (bus.dout !== 8'h21 || load !== 1'b0) begin failures++; $display("FAIL sim_wr_rd_1 got=%h/%b exp=21/0", bus.dout, load); end
        bus.din = 8'h88;
        @(negedge clk);
        bus.data_wr = 1'b0; bus.data_rd = 1'b0;
        checks++; if (bus.dout !== 8'h43 || load !== 1'b1 || new_count !== 16'h8899) begin
            failures++; $display("FAIL sim_wr_rd_2 got=%h/%b/%h exp=43/1/8899", bus.dout, load, new_count); end
    endtask

`ifdef COUNT_WRITE_HOLD_EN
    task automatic test_hold();
        cw(8'h30);
        wr(8'h34);
        for (int i = 0; i < 4; i++) begin
            checks++; if (count_hold !== 1'b1) begin failures++; $display("FAIL hold_active cyc=%0d got=%b exp=1", i, count_hold); end
            if (i < 3) idle(1);
        end
        wr(8'h12);
        checks++; if (count_hold !== 1'b0 || load !== 1'b1) begin failures++; $display("FAIL hold_release got=%b/%b exp=0/1", count_hold, load); end
        cw(8'h10);
        wr(8'h55);
        checks++; if (count_hold !== 1'b0) begin failures++; $display("FAIL hold_mode01 got=%b exp=0", count_hold); end
        cw(8'h30);
        wr(8'h34);
        cw(8'h30);
        checks++; if (count_hold !== 1'b0) begin failures++; $display("FAIL hold_cw_clear got=%b exp=0", count_hold); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_mode11_write();
        test_mode01_10();
        test_back_to_back();
        test_latch();
        test_repeat_latch();
        test_abort();
        test_reset_mid();
        test_simultaneous();
`ifdef COUNT_WRITE_HOLD_EN
        test_hold();
`endif
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_access_port.md
Name: counter_access_port

Overview:
- Bus-side access logic for one 8254 counter channel.
- Accepts the 8-bit control word and count-byte writes from the CPU interface, assembles them into a 16-bit count, and drives the counter core's load/new_count inputs.
- Provides the read path: live count or latched snapshot, returned byte-wise according to the programmed RW mode.

Parameters:
- RESET_RW, 2'b11, RW access mode after reset (01 LSB only, 10 MSB only, 11 LSB then MSB; 00 is illegal here).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cw_wr  in  1  one-cycle strobe: din is a control word for this channel
- data_wr  in  1  one-cycle strobe: din is a count byte
- data_rd  in  1  one-cycle strobe: read one count byte
- din  in  8  write data
- current_count  in  16  live count from the counter core
- dout  out  8  read data, registered
- load  out  1  one-cycle pulse to the counter core
- new_count  out  16  assembled count, valid while load=1 and held afterwards
- rw_mode  out  2  current RW mode (status/debug)

Behaviour:
- Reset (rst=0 at posedge):
  - rw_mode=RESET_RW, dout=0, load=0, new_count=0.
  - Write pointer and read pointer cleared to LSB; LSB holding register cleared; latch flag cleared.
- Control word decode: din[5:4]=RW field; other bits ignored.
  - RW!=00: rw_mode<=RW; write pointer, read pointer and latch flag cleared. A pending half-written count is discarded with no load.
  - RW=00 (latch command): if latch flag=0, snapshot current_count into latch register and set latch flag. If already latched, ignore. rw_mode and pointers unchanged.
- Count write (data_wr=1, cw_wr=0):
  - Mode 01: new_count<={8'h00,din}; load=1 in the following cycle.
  - Mode 10: new_count<={din,8'h00}; load=1 in the following cycle.
  - Mode 11, pointer=LSB: store din in LSB holding register; pointer<=MSB; no load.
  - Mode 11, pointer=MSB: new_count<={din,lsb_hold}; pointer<=LSB; load=1 in the following cycle.
  - Write latency: strobe at edge N, load high during cycle N+1 only.
  - Back-to-back completed writes produce back-to-back load pulses.
  - Value 0 is passed through unchanged; the core interprets it.
- Count read (data_rd=1):
  - Source is the latch register if latch flag=1, else current_count.
  - dout is updated at the same edge; valid from the next cycle until the next read or reset.
  - Mode 01: returns the low byte; latch flag cleared after the read.
  - Mode 10: returns the high byte; latch flag cleared after the read.
  - Mode 11: pointer=LSB returns the low byte and sets pointer<=MSB. pointer=MSB returns the high byte, sets pointer<=LSB and clears the latch flag.
  - Unlatched mode 11 reads sample current_count independently per byte; tearing is allowed and is the caller's responsibility.
- Simultaneous events:
  - cw_wr with data_wr: cw_wr wins; data byte ignored.
  - cw_wr with data_rd: the read is served with pre-command state, then the control word applies.
  - data_wr with data_rd: both processed; write and read pointers are independent.
- Reset mid-sequence: no load is issued for a half-written count. A pending load pulse is cancelled.

Optional Feature:
- Macro COUNT_WRITE_HOLD_EN.
- Defined: adds output count_hold (1 bit, reset 0), wired to the core's inverted enable.
  - count_hold=1 from the cycle after the LSB write in mode 11 until the cycle the load pulse is asserted.
  - Cleared by a control word or by reset.
  - Freezes counting between bytes, as the 8254 requires.
- Undefined: port absent; the core counts uninterrupted during two-byte writes.

Test Plan:
- Mode 11 write: cw din=8'h30, then data_wr 8'h34 and data_wr 8'h12 -> exactly one load pulse, one cycle after the second write, with new_count=16'h1234. No load after the first byte.
- Mode 01 and mode 10:
  - cw 8'h10, data_wr 8'hA5 -> new_count=16'h00A5, load pulse.
  - cw 8'h20, data_wr 8'h5A -> new_count=16'h5A00.
- Latch hold:
  - Mode 11, current_count=16'hBEEF, cw 8'h00 (latch).
  - current_count changes to 16'h0001.
  - Two reads -> dout 8'hEF then 8'hBE.
  - A third read returns the live low byte, 8'h01.
- Repeated latch: latch at 16'h1111, second latch command at 16'h2222 before any read -> reads return 8'h11, 8'h11.
- Abort mid-sequence: mode 11, write 8'h34, then cw 8'h30, then write 8'h78 and 8'h56 -> single load with new_count=16'h5678. Repeat with rst=0 after the first byte -> no load, all outputs 0.
- COUNT_WRITE_HOLD_EN: mode 11, write 8'h34, idle 3 cycles, write 8'h12 -> count_hold=1 for those cycles, falls in the load cycle; never asserted in mode 01.
